// File: rtl/tsc_pkg.sv
// Shared definitions for the TSC capture path: FSM state codes, error codes,
// word geometry and the default capture depth.
package tsc_pkg;

    localparam int unsigned BYTES_PER_WORD    = 4;
    localparam int unsigned DEFAULT_MAX_WORDS = 8;

    // Reader FSM state codes
    typedef logic [1:0] state_t;
    localparam state_t StIdle    = 2'd0;
    localparam state_t StRequest = 2'd1;
    localparam state_t StReceive = 2'd2;
    localparam state_t StFinish  = 2'd3;

    // err_code values; the first error latched in a dump is the one reported
    typedef logic [1:0] err_code_t;
    localparam err_code_t ErrNone     = 2'd0;
    localparam err_code_t ErrOverflow = 2'd1;
    localparam err_code_t ErrShort    = 2'd2;
    localparam err_code_t ErrTimeout  = 2'd3;

endpackage

// File: rtl/tsc_word_assembler.sv
// Packs a stream of MSB-first bytes into 32-bit words. word_valid is a
// combinational pulse in the same cycle as the last byte of a word, with the
// complete word presented on word.
module tsc_word_assembler
    import tsc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  tsc_byte,
    output logic [31:0] word,
    output logic        word_valid,
    output logic [1:0]  byte_idx
);

    // Only the three leading bytes of a word need storage; the fourth is
    // taken straight from the input when the word completes.
    logic [23:0] shift_q;
    logic [1:0]  idx_q;

    assign word       = {shift_q, tsc_byte};
    assign word_valid = byte_valid && (idx_q == 2'(BYTES_PER_WORD - 1));
    assign byte_idx   = idx_q;

    // Shift accepted bytes in and advance the byte index (wraps every word)
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else if (byte_valid) begin
            shift_q <= {shift_q[15:0], tsc_byte};
            idx_q   <= idx_q + 2'd1;
        end
    end

endmodule

// File: rtl/tsc_reader.sv
// Fetches the timestamp buffer from the TSC on user request: issues a one-cycle
// send request, captures the streamed words into a small memory and reports
// completion with done/err pulses and a latched error code.
module tsc_reader
    import tsc_pkg::*;
#(
    parameter int unsigned MAX_WORDS = DEFAULT_MAX_WORDS,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         dump_req,
    input  logic                         tsc_ready,
    output logic                         send_buf,
    input  logic [7:0]                   tsc_byte,
    input  logic                         tsc_byte_valid,
    input  logic                         tsc_complete,
    input  logic [$clog2(MAX_WORDS)-1:0] rd_addr,
    output logic [31:0]                  rd_data,
    output logic [$clog2(MAX_WORDS):0]   word_count,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [1:0]                   err_code
);

    localparam int unsigned AW = $clog2(MAX_WORDS);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] CountMax  = CW'(MAX_WORDS);
    localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   wc_q, wc_d;
    err_code_t       err_q, err_d;
    logic [TW-1:0]   timer_q, timer_d;

    logic            asm_clear;
    logic            asm_word_valid;
    logic [31:0]     asm_word;
    logic [1:0]      asm_byte_idx;

    logic            in_rx;
    logic            full;
    logic            accept;
    logic            drop;
    logic            short_word;

    logic [31:0]     mem [MAX_WORDS];

    assign in_rx  = (state_q == StReceive);
    assign full   = (wc_q == CountMax);
    assign accept = in_rx && tsc_byte_valid && !full;
    assign drop   = in_rx && tsc_byte_valid && full;

    // Index after this cycle's byte is non-zero: a word was left incomplete
    assign short_word = accept ? !asm_word_valid : (asm_byte_idx != 2'd0);

    tsc_word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (asm_clear),
        .byte_valid (accept),
        .tsc_byte   (tsc_byte),
        .word       (asm_word),
        .word_valid (asm_word_valid),
        .byte_idx   (asm_byte_idx)
    );

    // Next-state, counters, error latching and the send request
    always_comb begin
        state_d   = state_q;
        wc_d      = wc_q;
        err_d     = err_q;
        timer_d   = timer_q;
        asm_clear = 1'b0;
        send_buf  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (dump_req) begin
                    wc_d      = '0;
                    err_d     = ErrNone;
                    timer_d   = '0;
                    asm_clear = 1'b1;
                    state_d   = StRequest;
                end
            end

            StRequest: begin
                if (tsc_ready) begin
                    send_buf = 1'b1;
                    timer_d  = '0;
                    state_d  = StReceive;
                end
            end

            StReceive: begin
                if (asm_word_valid) begin
                    wc_d = wc_q + 1'b1;
                end
                if (drop && (err_q == ErrNone)) begin
                    err_d = ErrOverflow;
                end
                if (tsc_byte_valid) begin
                    timer_d = '0;
                end

                if (tsc_complete) begin
                    // Completion sees this cycle's byte already accepted
                    if (short_word && (err_d == ErrNone)) begin
                        err_d = ErrShort;
                    end
                    state_d = StFinish;
                end else if (!tsc_byte_valid) begin
                    if (timer_q == TimerLast) begin
                        if (err_q == ErrNone) begin
                            err_d = ErrTimeout;
                        end
                        state_d = StFinish;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end

            StFinish: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; reset wins over every other input
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            wc_q    <= '0;
            err_q   <= ErrNone;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            wc_q    <= wc_d;
            err_q   <= err_d;
            timer_q <= timer_d;
        end
    end

    // Capture memory write; word_valid only fires while below capacity
    always_ff @(posedge clk) begin
        if (!reset && asm_word_valid) begin
            mem[wc_q[AW-1:0]] <= asm_word;
        end
    end

    assign rd_data    = mem[rd_addr];
    assign word_count = wc_q;
    assign err_code   = err_q;
    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StFinish);
    assign err        = done && (err_q != ErrNone);

endmodule
